// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: window/matrix types, magnitude-mode encoding and kernel weights.
package sobel_pkg;

  localparam int SOBEL_PIXEL_WIDTH = 8;

  typedef logic [SOBEL_PIXEL_WIDTH-1:0] pixel_t;
  typedef logic [2:0][2:0][SOBEL_PIXEL_WIDTH-1:0] matrix3_t;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_MAX = 2'd1,
    MODE_GX  = 2'd2,
    MODE_GY  = 2'd3
  } sobel_mode_e;

  // 1-2-1 smoothing weights applied across the difference rows/columns
  localparam int SOBEL_K0 = 1;
  localparam int SOBEL_K1 = 2;
  localparam int SOBEL_K2 = 1;

endpackage

// File: rtl/sobel_mag_sat.sv
// Clips a wide gradient magnitude to pixel range and optionally binarizes it.
module sobel_mag_sat #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH+2:0] mag_i,
  input  logic                   thresh_en_i,
  input  logic [PIXEL_WIDTH-1:0] thresh_i,
  output logic [PIXEL_WIDTH-1:0] pixel_o,
  output logic                   sat_o
);

  logic [PIXEL_WIDTH-1:0] clip;

  assign sat_o   = |mag_i[PIXEL_WIDTH+2:PIXEL_WIDTH];
  assign clip    = sat_o ? '1 : mag_i[PIXEL_WIDTH-1:0];
  assign pixel_o = thresh_en_i ? ((clip >= thresh_i) ? '1 : '0) : clip;

endmodule

// File: rtl/sobel_core_pipe.sv
// Three-stage Sobel gradient pipeline with valid/ready flow control and a clip-event counter.
module sobel_core_pipe
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [9*PIXEL_WIDTH-1:0] window_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               mode_i,
  input  logic                     thresh_en_i,
  input  logic [PIXEL_WIDTH-1:0]   thresh_i,
  output logic [PIXEL_WIDTH-1:0]   pixel_o,
  output logic                     sat_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     sat_clear_i,
  output logic [CNT_WIDTH-1:0]     sat_count_o
);

  localparam int PW = PIXEL_WIDTH;
  localparam int DW = PW + 1;
  localparam int GW = PW + 3;
  localparam logic signed [GW-1:0] W0 = GW'(SOBEL_K0);
  localparam logic signed [GW-1:0] W1 = GW'(SOBEL_K1);
  localparam logic signed [GW-1:0] W2 = GW'(SOBEL_K2);

  logic advance;
  assign advance = ~valid_o | ready_i;
  assign ready_o = advance;

  logic [PW-1:0] p [9];
  logic signed [DW-1:0] dx_c [3];
  logic signed [DW-1:0] dy_c [3];

  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = window_i[i*PW +: PW];
    for (int k = 0; k < 3; k++) begin
      dx_c[k] = $signed({1'b0, p[3*k+2]}) - $signed({1'b0, p[3*k]});
      dy_c[k] = $signed({1'b0, p[k]}) - $signed({1'b0, p[6+k]});
    end
  end

  // S1: per-row horizontal and per-column vertical differences
  logic                 v1_q;
  logic signed [DW-1:0] dx_q [3];
  logic signed [DW-1:0] dy_q [3];
  sobel_mode_e          mode1_q;
  logic                 ten1_q;
  logic [PW-1:0]        th1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
    end else if (advance) begin
      v1_q    <= valid_i;
      dx_q    <= dx_c;
      dy_q    <= dy_c;
      mode1_q <= sobel_mode_e'(mode_i);
      ten1_q  <= thresh_en_i;
      th1_q   <= thresh_i;
    end
  end

  // S2: weighted gradients and their magnitudes
  logic signed [GW-1:0] gx_c, gy_c;
  logic [GW-1:0]        ax_c, ay_c;

  always_comb begin
    gx_c = W0 * GW'(dx_q[0]) + W1 * GW'(dx_q[1]) + W2 * GW'(dx_q[2]);
    gy_c = W0 * GW'(dy_q[0]) + W1 * GW'(dy_q[1]) + W2 * GW'(dy_q[2]);
    ax_c = gx_c[GW-1] ? -gx_c : gx_c;
    ay_c = gy_c[GW-1] ? -gy_c : gy_c;
  end

  logic                 v2_q;
  logic signed [GW-1:0] gx_q, gy_q;
  logic [GW-1:0]        ax_q, ay_q;
  sobel_mode_e          mode2_q;
  logic                 ten2_q;
  logic [PW-1:0]        th2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2_q <= 1'b0;
    end else if (advance) begin
      v2_q    <= v1_q;
      gx_q    <= gx_c;
      gy_q    <= gy_c;
      ax_q    <= ax_c;
      ay_q    <= ay_c;
      mode2_q <= mode1_q;
      ten2_q  <= ten1_q;
      th2_q   <= th1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && v2_q) begin
      assert (ax_q == (gx_q[GW-1] ? -gx_q : gx_q) && ay_q == (gy_q[GW-1] ? -gy_q : gy_q));
    end
  end

  // S3: mode select, clip/threshold, output register
  logic [GW-1:0] mag_c;
  logic [PW-1:0] pix_c;
  logic          sat_c;

  always_comb begin
    mag_c = ay_q;
    case (mode2_q)
      MODE_SUM: mag_c = ax_q + ay_q;
      MODE_MAX: mag_c = (ax_q >= ay_q) ? ax_q : ay_q;
      MODE_GX:  mag_c = ax_q;
      MODE_GY:  mag_c = ay_q;
      default:  mag_c = ay_q;
    endcase
  end

  sobel_mag_sat #(.PIXEL_WIDTH(PW)) u_mag_sat (
    .mag_i       (mag_c),
    .thresh_en_i (ten2_q),
    .thresh_i    (th2_q),
    .pixel_o     (pix_c),
    .sat_o       (sat_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      pixel_o <= '0;
      sat_o   <= 1'b0;
    end else if (advance) begin
      valid_o <= v2_q;
      pixel_o <= pix_c;
      sat_o   <= sat_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || sat_clear_i) begin
      sat_count_o <= '0;
    end else if (valid_o && ready_i && sat_o && !(&sat_count_o)) begin
      sat_count_o <= sat_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_core_pipe.sv
// Directed self-checking bench for sobel_core_pipe (counter narrowed to 3 bits to reach its ceiling).
module tb_sobel_core_pipe;

  logic        clk_i;
  logic        rst_i;
  logic [71:0] window_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  mode_i;
  logic        thresh_en_i;
  logic [7:0]  thresh_i;
  logic [7:0]  pixel_o;
  logic        sat_o;
  logic        valid_o;
  logic        ready_i;
  logic        sat_clear_i;
  logic [2:0]  sat_count_o;

  int checks;
  int failures;

  sobel_core_pipe #(.PIXEL_WIDTH(8), .CNT_WIDTH(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .window_i    (window_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mode_i      (mode_i),
    .thresh_en_i (thresh_en_i),
    .thresh_i    (thresh_i),
    .pixel_o     (pixel_o),
    .sat_o       (sat_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .sat_clear_i (sat_clear_i),
    .sat_count_o (sat_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] win_cols(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0, c2, c1, c0, c2, c1, c0};
  endfunction

  // rows: top {20,20,10}, middle {0,0,10}, bottom {0,0,10} -> gx=20, gy=60
  localparam logic [71:0] WIN_D = {8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd20, 8'd20};

  task automatic run_beat(input logic [71:0] w, input logic [1:0] m, input logic te, input logic [7:0] th,
                          input logic [7:0] exp_pix, input logic exp_sat, input string nm);
    @(negedge clk_i);
    window_i = w; mode_i = m; thresh_en_i = te; thresh_i = th; valid_i = 1'b1; ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL %s_accept: ready_o=%b expected 1", nm, ready_o); end
    for (int lat = 1; lat <= 3; lat++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      window_i = '0;
      checks++;
      if (valid_o !== (lat == 3)) begin
        failures++; $display("FAIL %s_latency%0d: valid_o=%b expected %b", nm, lat, valid_o, (lat == 3));
      end
    end
    checks++;
    if (pixel_o !== exp_pix || sat_o !== exp_sat) begin
      failures++;
      $display("FAIL %s: pixel_o=%0d sat_o=%b expected pixel_o=%0d sat_o=%b", nm, pixel_o, sat_o, exp_pix, exp_sat);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; sat_clear_i = 1'b0;
    window_i = '0; mode_i = 2'd0; thresh_en_i = 1'b0; thresh_i = 8'd0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || pixel_o !== 8'd0 || sat_o !== 1'b0 || sat_count_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: valid_o=%b pixel_o=%0d sat_o=%b sat_count_o=%0d expected all 0",
               valid_o, pixel_o, sat_o, sat_count_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: ready_o=%b expected 1", ready_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++; $display("FAIL post_reset: ready_o=%b valid_o=%b expected 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_flat();
    run_beat({9{8'd100}}, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0, "flat_mode0");
  endtask

  task automatic test_vertical_edge();
    run_beat(win_cols(8'd0, 8'd0, 8'd10), 2'd0, 1'b0, 8'd0, 8'd40, 1'b0, "edge_mode0");
    run_beat(win_cols(8'd0, 8'd0, 8'd10), 2'd3, 1'b0, 8'd0, 8'd0, 1'b0, "edge_mode3");
    run_beat(win_cols(8'd10, 8'd0, 8'd0), 2'd2, 1'b0, 8'd0, 8'd40, 1'b0, "edge_neg_gx");
  endtask

  task automatic test_saturation();
    run_beat(win_cols(8'd0, 8'd0, 8'd255), 2'd0, 1'b0, 8'd0, 8'd255, 1'b1, "sat_mode0");
    @(negedge clk_i);
    checks++;
    if (sat_count_o !== 3'd1) begin
      failures++; $display("FAIL sat_count_after_one: sat_count_o=%0d expected 1", sat_count_o);
    end
  endtask

  task automatic test_modes_threshold();
    run_beat(WIN_D, 2'd0, 1'b0, 8'd0, 8'd80, 1'b0, "d_mode0");
    run_beat(WIN_D, 2'd1, 1'b0, 8'd0, 8'd60, 1'b0, "d_mode1");
    run_beat(WIN_D, 2'd2, 1'b0, 8'd0, 8'd20, 1'b0, "d_mode2");
    run_beat(WIN_D, 2'd3, 1'b0, 8'd0, 8'd60, 1'b0, "d_mode3");
    run_beat(WIN_D, 2'd0, 1'b1, 8'd50, 8'd255, 1'b0, "d_thr_mode0");
    run_beat(WIN_D, 2'd2, 1'b1, 8'd50, 8'd0, 1'b0, "d_thr_mode2");
    run_beat(WIN_D, 2'd1, 1'b1, 8'd60, 8'd255, 1'b0, "d_thr_equal");
    run_beat(WIN_D, 2'd1, 1'b1, 8'd61, 8'd0, 1'b0, "d_thr_above");
    run_beat(win_cols(8'd0, 8'd0, 8'd255), 2'd0, 1'b1, 8'd50, 8'd255, 1'b1, "sat_thr");
  endtask

  task automatic test_back_to_back();
    logic [71:0] w [5];
    logic [1:0]  m [5];
    logic        te [5];
    logic [7:0]  ep [5];
    w[0] = win_cols(8'd0, 8'd0, 8'd10); m[0] = 2'd0; te[0] = 1'b0; ep[0] = 8'd40;
    w[1] = win_cols(8'd0, 8'd0, 8'd10); m[1] = 2'd3; te[1] = 1'b0; ep[1] = 8'd0;
    w[2] = WIN_D;                       m[2] = 2'd1; te[2] = 1'b0; ep[2] = 8'd60;
    w[3] = WIN_D;                       m[3] = 2'd0; te[3] = 1'b1; ep[3] = 8'd255;
    w[4] = WIN_D;                       m[4] = 2'd2; te[4] = 1'b1; ep[4] = 8'd0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk_i);
      ready_i = 1'b1; thresh_i = 8'd50;
      if (cyc < 5) begin
        valid_i = 1'b1; window_i = w[cyc]; mode_i = m[cyc]; thresh_en_i = te[cyc];
      end else begin
        valid_i = 1'b0; thresh_en_i = 1'b0; mode_i = 2'd0;
      end
      #1;
      if (cyc >= 3 && cyc < 8) begin
        checks++;
        if (valid_o !== 1'b1 || pixel_o !== ep[cyc-3]) begin
          failures++;
          $display("FAIL b2b_beat%0d: valid_o=%b pixel_o=%0d expected 1/%0d", cyc - 3, valid_o, pixel_o, ep[cyc-3]);
        end
      end else begin
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle%0d: valid_o=%b expected 0", cyc, valid_o); end
      end
    end
  endtask

  task automatic test_stall_stream();
    int in_idx;
    int out_idx;
    logic [7:0] hold_pix;
    logic holding;
    in_idx = 0; out_idx = 0; holding = 1'b0; hold_pix = '0;
    mode_i = 2'd0; thresh_en_i = 1'b0;
    for (int cyc = 0; cyc < 60 && out_idx < 10; cyc++) begin
      @(negedge clk_i);
      ready_i = !(cyc >= 5 && cyc < 10);
      if (in_idx < 10) begin
        valid_i = 1'b1; window_i = win_cols(8'd0, 8'd0, 8'(in_idx + 1));
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (valid_o && !ready_i) begin
        if (holding) begin
          checks++;
          if (pixel_o !== hold_pix) begin
            failures++; $display("FAIL stall_hold: pixel_o=%0d expected %0d", pixel_o, hold_pix);
          end
        end else begin
          hold_pix = pixel_o; holding = 1'b1;
        end
      end else begin
        holding = 1'b0;
      end
      if (valid_o && ready_i) begin
        checks++;
        if (pixel_o !== 8'((out_idx + 1) * 4)) begin
          failures++; $display("FAIL stall_order%0d: pixel_o=%0d expected %0d", out_idx, pixel_o, (out_idx + 1) * 4);
        end
        out_idx++;
      end
      if (valid_i && ready_o) in_idx++;
    end
    checks++;
    if (out_idx != 10) begin failures++; $display("FAIL stall_count: outputs=%0d expected 10", out_idx); end
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b0) begin failures++; $display("FAIL stall_extra%0d: valid_o=%b expected 0", k, valid_o); end
    end
  endtask

  task automatic test_count_saturate();
    @(negedge clk_i);
    sat_clear_i = 1'b1;
    @(negedge clk_i);
    sat_clear_i = 1'b0;
    checks++;
    if (sat_count_o !== 3'd0) begin failures++; $display("FAIL count_clear: sat_count_o=%0d expected 0", sat_count_o); end
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clk_i);
      ready_i = 1'b1; mode_i = 2'd0; thresh_en_i = 1'b0;
      valid_i = (cyc < 9);
      window_i = win_cols(8'd0, 8'd0, 8'd255);
      #1;
      if (cyc >= 3 && cyc < 12) begin
        checks++;
        if (valid_o !== 1'b1 || sat_o !== 1'b1 || pixel_o !== 8'd255) begin
          failures++;
          $display("FAIL count_stream%0d: valid_o=%b sat_o=%b pixel_o=%0d expected 1/1/255", cyc, valid_o, sat_o, pixel_o);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (sat_count_o !== 3'd6) begin failures++; $display("FAIL count_six: sat_count_o=%0d expected 6", sat_count_o); end
      end
    end
    checks++;
    if (sat_count_o !== 3'd7) begin failures++; $display("FAIL count_ceiling: sat_count_o=%0d expected 7", sat_count_o); end
  endtask

  task automatic test_clear_priority();
    @(negedge clk_i);
    window_i = win_cols(8'd0, 8'd0, 8'd255); mode_i = 2'd0; thresh_en_i = 1'b0;
    valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    sat_clear_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b1 || sat_o !== 1'b1 || sat_count_o !== 3'd7) begin
      failures++;
      $display("FAIL clear_setup: valid_o=%b sat_o=%b sat_count_o=%0d expected 1/1/7", valid_o, sat_o, sat_count_o);
    end
    @(negedge clk_i);
    sat_clear_i = 1'b0;
    checks++;
    if (sat_count_o !== 3'd0) begin failures++; $display("FAIL clear_priority: sat_count_o=%0d expected 0", sat_count_o); end
  endtask

  task automatic test_reset_mid_stream();
    logic seen;
    run_beat(win_cols(8'd0, 8'd0, 8'd255), 2'd0, 1'b0, 8'd0, 8'd255, 1'b1, "pre_reset_sat");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      ready_i = 1'b0; valid_i = 1'b1;
      window_i = win_cols(8'd0, 8'd0, 8'(50 + i)); mode_i = 2'd0; thresh_en_i = 1'b0;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || sat_count_o !== 3'd1) begin
      failures++; $display("FAIL rst_setup: valid_o=%b sat_count_o=%0d expected 1/1", valid_o, sat_count_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || pixel_o !== 8'd0 || sat_o !== 1'b0 || sat_count_o !== 3'd0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid: valid_o=%b pixel_o=%0d sat_o=%b sat_count_o=%0d ready_o=%b expected 0/0/0/0/1",
               valid_o, pixel_o, sat_o, sat_count_o, ready_o);
    end
    rst_i = 1'b0; ready_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_stale: stale_valid=%b ready_o=%b expected 0/1", seen, ready_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_flat();
    test_vertical_edge();
    test_saturation();
    test_modes_threshold();
    test_back_to_back();
    test_stall_stream();
    test_count_saturate();
    test_clear_priority();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_core_pipe.md
SOBEL_CORE_PIPE -- requirements
Module: sobel_core_pipe

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel, input and output.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the saturation event counter.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port window_i, input, 9*PIXEL_WIDTH bits: 3x3 window; pixel (r,c) at slice index 3*r+c, r = row 0..2 top to bottom, c = column 0..2 left to right.
REQ-006 SHALL have port valid_i, input, 1 bit: window_i, mode_i, thresh_en_i and thresh_i are valid this cycle.
REQ-007 SHALL have port ready_o, output, 1 bit: block accepts an input beat this cycle.
REQ-008 SHALL have port mode_i, input, 2 bits: magnitude mode; 0 = |gx|+|gy|, 1 = max(|gx|,|gy|), 2 = |gx|, 3 = |gy|.
REQ-009 SHALL have port thresh_en_i, input, 1 bit: binarize the output.
REQ-010 SHALL have port thresh_i, input, PIXEL_WIDTH bits: binarization threshold.
REQ-011 SHALL have port pixel_o, output, PIXEL_WIDTH bits: result pixel.
REQ-012 SHALL have port sat_o, output, 1 bit: the current output beat was clipped.
REQ-013 SHALL have port valid_o, output, 1 bit: pixel_o and sat_o are valid.
REQ-014 SHALL have port ready_i, input, 1 bit: downstream accepts the output beat.
REQ-015 SHALL have port sat_clear_i, input, 1 bit: clear sat_count_o.
REQ-016 SHALL have port sat_count_o, output, CNT_WIDTH bits: number of clipped beats accepted downstream.

Function
REQ-017 SHALL compute gx = sum over rows of k_r*(p(r,2)-p(r,0)), with k = 1,2,1.
REQ-018 SHALL compute gy = sum over columns of k_c*(p(0,c)-p(2,c)), with k = 1,2,1.
REQ-019 SHALL hold gx and gy as signed values, PIXEL_WIDTH+3 bits; no intermediate overflow is permitted.
REQ-020 SHALL compute the magnitude unsigned, PIXEL_WIDTH+3 bits, per mode_i.
REQ-021 SHALL saturate a magnitude greater than 2^PIXEL_WIDTH-1 to all-ones and set sat_o=1; otherwise it truncates losslessly with sat_o=0.
REQ-022 SHALL, when thresh_en_i=1, output all-ones if the saturated magnitude >= thresh_i, else 0; sat_o still reports clipping.
REQ-023 SHALL carry mode_i, thresh_en_i and thresh_i alongside their window through the pipeline; changing them mid-stream SHALL affect only later beats.
REQ-024 SHALL use a 3-stage pipeline:
  - S1 registers column/row differences.
  - S2 registers gx, gy, |gx|, |gy|.
  - S3 registers the mode result, saturation and threshold into pixel_o/sat_o/valid_o.
REQ-025 SHALL have a latency of exactly 3 cycles from an accepted beat (valid_i & ready_o) to valid_o, with no stall.
REQ-026 SHALL define advance = ~valid_o | ready_i, SHALL drive ready_o = advance combinationally, and all stages SHALL shift only when advance=1.
REQ-027 SHALL hold pixel_o, sat_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-028 SHALL sustain a throughput of 1 beat/cycle with ready_i held high.
REQ-029 SHALL propagate bubbles (valid_i=0) as invalid stage slots and SHALL NOT collapse them.
REQ-030 SHALL increment sat_count_o on valid_o & ready_i & sat_o, saturating at all-ones with no wrap.
REQ-031 SHALL give sat_clear_i priority over a simultaneous increment; the counter becomes 0.

Reset
REQ-032 SHALL, on rst_i=1 at a clock edge, clear all stage valid bits, valid_o, pixel_o, sat_o and sat_count_o to 0.
REQ-033 SHALL discard in-flight beats when reset is asserted mid-stream; none SHALL appear after reset.
REQ-034 SHALL drive ready_o=1 during and after reset, because valid_o=0.

Structure
REQ-035 SHALL place the mode encoding (enum typedef) and the kernel-weight constants in the shared sobel package, alongside the existing matrix typedefs.
REQ-036 SHALL implement the saturate/threshold logic in one sub-module, sobel_mag_sat, instantiated in S3.

Verification
REQ-037 SHALL cover: all nine pixels = 100, mode 0 -> pixel_o=0, sat_o=0, valid 3 cycles after acceptance.
REQ-038 SHALL cover: column 0 = 0, column 2 = 10, rest 0, mode 0 -> gx=40, gy=0, pixel_o=40; mode 3 -> pixel_o=0.
REQ-039 SHALL cover: column 0 = 0, column 2 = 255, mode 0 -> magnitude 1020, pixel_o=255, sat_o=1; sat_count_o=1 after the beat is accepted.
REQ-040 SHALL cover: top row = 20, bottom row = 0, column 2 = 10, mode 1 vs 0 -> distinct results matching the golden model; thresh_en=1 with thresh_i=50 -> 255 or 0 per magnitude.
REQ-041 SHALL cover: a stream of 10 beats with ready_i low for 5 cycles mid-stream -> no loss, no duplication, in-order outputs, pixel_o stable while stalled.
REQ-042 SHALL cover: rst_i pulsed with 3 beats in flight -> valid_o=0 next cycle, counter=0, no stale beat emitted afterwards.
